// File: rtl/t3d_abs_responder.sv
// T3D encoder emulator: receives a request byte over a half-duplex 8N1 link and replies with CF, SF, ABS0-2, CRC.
// Define T3D_ABS_RESP_MULTITURN_EN to also answer request 8'h8A with the multi-turn count.
module t3d_abs_responder #(
  parameter int unsigned ClkFrequency     = 32400000,
  parameter int unsigned Baud             = 2500000,
  parameter int unsigned TurnaroundCycles = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        tx_enable,
  input  logic [16:0] position_in,
  input  logic [7:0]  status_in,
  input  logic [23:0] turns_in,
  output logic        busy,
  output logic [15:0] req_count
);

  localparam int unsigned BIT_CYCLES = ClkFrequency / Baud;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {S_IDLE, S_RX, S_TURN, S_TX} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_rx_meta, r_rx_sync, r_rx_prev;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_bit, w_bit_nxt;
  logic [2:0]         r_byte, w_byte_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic               r_tx, w_tx_nxt, r_tx_en, w_tx_en_nxt, r_busy, w_busy_nxt;
  logic [15:0]        r_req_count, w_count_nxt;
  logic [7:0]         r_id, r_status, r_d2, r_d3, r_d4, w_cur_byte;
  logic               w_start, w_tick, w_stop_smp, w_match, w_accept, w_latch;

  assign w_start    = r_rx_prev & ~r_rx_sync;
  assign w_tick     = (r_cnt == '0);
  assign w_stop_smp = (r_state == S_RX) && w_tick && (r_bit == 4'd8);
  assign w_accept   = w_stop_smp && r_rx_sync && w_match;

`ifdef T3D_ABS_RESP_MULTITURN_EN
  assign w_match = (r_shift == 8'h02) || (r_shift == 8'h8A);
`else
  assign w_match = (r_shift == 8'h02);
  logic w_turns_unused;
  assign w_turns_unused = ^turns_in;
`endif

  // Reply byte currently on the wire; the last one is the XOR check byte
  always_comb begin
    case (r_byte)
      3'd0:    w_cur_byte = r_id;
      3'd1:    w_cur_byte = r_status;
      3'd2:    w_cur_byte = r_d2;
      3'd3:    w_cur_byte = r_d3;
      3'd4:    w_cur_byte = r_d4;
      default: w_cur_byte = r_id ^ r_status ^ r_d2 ^ r_d3 ^ r_d4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RX;
      S_RX:    if (w_stop_smp) w_state_nxt = w_accept ? S_TURN : S_IDLE;
      S_TURN:  if (w_tick) w_state_nxt = S_TX;
      S_TX:    if (w_tick && (r_bit == 4'd9) && (r_byte == 3'd5)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_tx_en_nxt = r_tx_en;
    w_busy_nxt  = r_busy;
    w_count_nxt = r_req_count;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // first sample lands mid-way through data bit 0
        if (w_start) begin
          w_cnt_nxt = CNT_W'(BIT_CYCLES + BIT_CYCLES / 2 - 1);
          w_bit_nxt = '0;
        end
      end
      S_RX: begin
        if (w_tick) begin
          w_cnt_nxt = CNT_W'(BIT_CYCLES - 1);
          w_bit_nxt = r_bit + 4'd1;
          if (r_bit < 4'd8) begin
            w_shift_nxt = {r_rx_sync, r_shift[7:1]};
          end else if (w_accept) begin
            w_latch     = 1'b1;
            w_busy_nxt  = 1'b1;
            w_count_nxt = r_req_count + 16'd1;
            w_cnt_nxt   = CNT_W'(TurnaroundCycles - 1);
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_TURN: begin
        if (w_tick) begin
          w_tx_nxt   = 1'b0;
          w_cnt_nxt  = CNT_W'(BIT_CYCLES - 1);
          w_bit_nxt  = '0;
          w_byte_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_tx_en_nxt = 1'b1;
        end
      end
      S_TX: begin
        if (w_tick) begin
          w_cnt_nxt = CNT_W'(BIT_CYCLES - 1);
          if (r_bit == 4'd9) begin
            if (r_byte == 3'd5) begin
              w_tx_nxt    = 1'b1;
              w_tx_en_nxt = 1'b0;
              w_busy_nxt  = 1'b0;
            end else begin
              w_byte_nxt = r_byte + 3'd1;
              w_bit_nxt  = '0;
              w_tx_nxt   = 1'b0;
            end
          end else begin
            w_bit_nxt = r_bit + 4'd1;
            w_tx_nxt  = (r_bit == 4'd8) ? 1'b1 : w_cur_byte[r_bit[2:0]];
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_shift     <= '0;
      r_tx        <= 1'b1;
      r_tx_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_req_count <= '0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_byte      <= w_byte_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_tx_en     <= w_tx_en_nxt;
      r_busy      <= w_busy_nxt;
      r_req_count <= w_count_nxt;
    end
  end

  // Snapshot of the reply payload taken on the accepting stop-bit sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id     <= '0;
      r_status <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      r_d4     <= '0;
    end else if (w_latch) begin
      r_id     <= r_shift;
      r_status <= status_in;
`ifdef T3D_ABS_RESP_MULTITURN_EN
      if (r_shift == 8'h8A) begin
        r_d2 <= turns_in[7:0];
        r_d3 <= turns_in[15:8];
        r_d4 <= turns_in[23:16];
      end else begin
        r_d2 <= position_in[7:0];
        r_d3 <= position_in[15:8];
        r_d4 <= {7'b0, position_in[16]};
      end
`else
      r_d2     <= position_in[7:0];
      r_d3     <= position_in[15:8];
      r_d4     <= {7'b0, position_in[16]};
`endif
    end
  end

  assign tx        = r_tx;
  assign tx_enable = r_tx_en;
  assign busy      = r_busy;
  assign req_count = r_req_count;

endmodule
